// File: rtl/imem_loader_if.sv
// imem_loader_if -- bundle of the loader's stream, memory-write and status
// signals.
//   start            : begin a load (host -> loader)
//   byte_valid       : byte_data holds a stream byte (host -> loader)
//   byte_data[7:0]   : load-stream byte (host -> loader)
//   byte_ready       : loader accepts a byte this cycle (loader -> host)
//   mem_write_enable : one-cycle instruction-memory write strobe
//   mem_address[31:0]: word-aligned byte address of the write
//   mem_write_data   : instruction word being written
//   cpu_hold         : keeps the CPU in reset while high
//   done / error     : outcome of the most recent load
// Modports: master = host/memory side, slave = the loader itself.
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_write_enable, mem_address, mem_write_data,
           cpu_hold, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_write_enable, mem_address, mem_write_data,
           cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- receives a framed byte stream and writes it into
// instruction memory while holding the CPU in reset.
// Frame: N[7:0], N[15:8], 4*N little-endian payload bytes, XOR checksum of
// the payload bytes only.
// Ports:
//   clock : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : imem_loader_if.slave (stream handshake, memory write, status)
// Parameter DEPTH_LOG2: log2 of memory capacity in 32-bit words.
module imem_loader #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic          clock,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  // 33 bits so the capacity still fits for large DEPTH_LOG2.
  localparam logic [32:0] MAX_WORDS = 33'd1 << DEPTH_LOG2;

  logic [2:0]  state_reg, state_next;
  logic [15:0] len_reg;
  logic [15:0] word_idx_reg;
  logic [1:0]  lane_reg;
  logic [31:0] word_reg;
  logic [7:0]  csum_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  logic        byte_ready;
  logic        accept;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;
  logic [31:0] word_assembled;

  assign byte_ready = (state_reg == LEN_LO) || (state_reg == LEN_HI) ||
                      (state_reg == DATA)   || (state_reg == CHECK);
  assign accept     = bus.byte_valid && byte_ready;

  // Length as it will be once the high byte in LEN_HI is captured.
  assign len_full  = {bus.byte_data, len_reg[7:0]};
  assign len_bad   = (len_full == 16'd0) || ({17'd0, len_full} > MAX_WORDS);
  assign last_word = (word_idx_reg == len_reg - 16'd1);

  // The incoming byte replaces the current lane; other lanes keep what was
  // already collected. Lane 3 completes the word, which is then fed straight
  // into the write-data register so the strobe follows one cycle later.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_assembled[gi*8 +: 8] =
        (lane_reg == 2'(gi)) ? bus.byte_data : word_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERROR: if (bus.start) state_next = LEN_LO;
      LEN_LO:            if (accept) state_next = LEN_HI;
      LEN_HI:            if (accept) state_next = len_bad ? ERROR : DATA;
      DATA:              if (accept && lane_reg == 2'd3) state_next = WRITE;
      WRITE:             state_next = last_word ? CHECK : DATA;
      CHECK:             if (accept)
                           state_next = (bus.byte_data == csum_reg) ? DONE : ERROR;
      default:           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      len_reg      <= 16'd0;
      word_idx_reg <= 16'd0;
      lane_reg     <= 2'd0;
      word_reg     <= 32'd0;
      csum_reg     <= 8'd0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            word_idx_reg <= 16'd0;
            csum_reg     <= 8'd0;
            lane_reg     <= 2'd0;
          end
        end
        LEN_LO: begin
          if (accept) len_reg[7:0] <= bus.byte_data;
        end
        LEN_HI: begin
          if (accept) begin
            len_reg[15:8] <= bus.byte_data;
            lane_reg      <= 2'd0;
          end
        end
        DATA: begin
          if (accept) begin
            csum_reg <= csum_reg ^ bus.byte_data;
            word_reg <= word_assembled;
            lane_reg <= lane_reg + 2'd1;
            if (lane_reg == 2'd3) begin
              addr_reg  <= {14'd0, word_idx_reg, 2'b00};
              wdata_reg <= word_assembled;
            end
          end
        end
        WRITE: begin
          if (!last_word) word_idx_reg <= word_idx_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode directly from the state, so the asynchronous
  // reset of state_reg puts them at their reset values immediately.
  assign bus.byte_ready       = byte_ready;
  assign bus.mem_write_enable = (state_reg == WRITE);
  assign bus.mem_address      = addr_reg;
  assign bus.mem_write_data   = wdata_reg;
  assign bus.done             = (state_reg == DONE);
  assign bus.error            = (state_reg == ERROR);
  assign bus.cpu_hold         = (state_reg != DONE);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, giving the log2 of the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin a load; honoured only in IDLE, DONE and ERROR.
REQ-005 SHALL have port byte_valid, input, 1 bit: byte_data holds a valid stream byte.
REQ-006 SHALL have port byte_data, input, 8 bits: load-stream byte.
REQ-007 SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-008 SHALL have port mem_write_enable, output, 1 bit: one-cycle write strobe to instruction memory.
REQ-009 SHALL have port mem_address, output, 32 bits: byte address of the write, word-aligned, in the pc address space.
REQ-010 SHALL have port mem_write_data, output, 32 bits: instruction word to write.
REQ-011 SHALL have port cpu_hold, output, 1 bit: holds the CPU in reset while high.
REQ-012 SHALL have port done, output, 1 bit: last load completed with a good checksum.
REQ-013 SHALL have port error, output, 1 bit: last load failed.

Function
REQ-014 SHALL accept a byte only on a rising edge where byte_valid=1 and byte_ready=1.
REQ-015 SHALL accept a stream frame of: length low byte, length high byte (N, 16-bit word count), 4*N payload bytes, 1 checksum byte.
REQ-016 SHALL assemble each payload word little-endian: the first byte goes to bits 7:0 and the fourth byte to bits 31:24.
REQ-017 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-018 SHALL drive byte_ready=1 only in LEN_LO, LEN_HI, DATA and CHECK.
REQ-019 SHALL, in IDLE, DONE or ERROR with start=1, go to LEN_LO, clear done and error, set cpu_hold=1, and reset the word index and the checksum to 0.
REQ-020 SHALL, in LEN_LO, capture the accepted byte as N[7:0] and go to LEN_HI.
REQ-021 SHALL, in LEN_HI, capture the accepted byte as N[15:8] and go to ERROR if N=0 or N>2**DEPTH_LOG2, otherwise to DATA with byte lane 0.
REQ-022 SHALL, in DATA, XOR each accepted byte into the running checksum and place it in the current lane, moving to WRITE after the fourth byte.
REQ-023 SHALL, in WRITE, assert mem_write_enable for exactly one cycle with mem_address=4*word_index and mem_write_data equal to the assembled word.
REQ-024 SHALL, on leaving WRITE, go to CHECK if word_index=N-1, otherwise increment word_index and return to DATA.
REQ-025 SHALL give a write latency of one cycle: if the fourth byte is accepted at edge k, mem_write_enable is high between edges k and k+1.
REQ-026 SHALL, in CHECK, compare the accepted byte with the running checksum and go to DONE on a match, otherwise to ERROR.
REQ-027 SHALL drive done=1 and cpu_hold=0 in DONE, and error=1 and cpu_hold=1 in ERROR; cpu_hold SHALL be 1 in every other state.
REQ-028 SHALL hold mem_address and mem_write_data stable between write strobes.
REQ-029 SHALL ignore start in LEN_LO, LEN_HI, DATA, WRITE and CHECK.
REQ-030 SHALL stall in place when byte_valid=0, with no timeout.
REQ-031 SHALL not include the two length bytes in the checksum.

Reset
REQ-032 SHALL, while reset=1 and independent of clock, force state=IDLE, byte_ready=0, mem_write_enable=0, mem_address=0, mem_write_data=0, cpu_hold=1, done=0 and error=0.
REQ-033 SHALL, on reset mid-load, discard any partial word and counters; words already written are not rewritten.

Verification
REQ-034 SHALL cover: start, then bytes 01 00 13 05 A0 00 B6 -> one write, addr 0x0, data 0x00A00513, then done=1 and cpu_hold=0.
REQ-035 SHALL cover: N=2 with byte_valid gaps of 0-3 cycles -> exactly two strobes at addresses 0x0 and 0x4, and byte_ready low during each WRITE.
REQ-036 SHALL cover: the REQ-034 frame with checksum B7 -> error=1, done=0, cpu_hold=1; a following good frame -> done=1.
REQ-037 SHALL cover: length 00 00 -> ERROR after the second byte with no write; length 01 01 (257) with DEPTH_LOG2=8 -> ERROR with no write.
REQ-038 SHALL cover: reset asserted after 2 payload bytes -> all outputs take reset values without waiting for a clock edge; a fresh start and full frame then load correctly from address 0.
REQ-039 SHALL cover: a start pulse during DATA -> no effect, and the frame completes normally.
